ir_digit_entry: RTL and testbench

- Parametrised key-entry and display-buffer block placed between IR_RECEIVE and the SEG_HEX decoders.
- Turns decoded IR keycodes (oDATA[23:16]) into an NDIG-digit right-aligned decimal entry field, with backspace, clear and enter handling.
- Provides per-digit blanking outputs: leading-zero blanking, blinking in the locked state, and a timed error flash.
- Successor to the fixed 5-digit direct digit wiring; the display width and all timing are generic.

---
 rtl/ir_digit_entry_if.sv | 26 ++
 rtl/ir_digit_entry.sv | 189 ++++++++++++++++++
 tb/tb_ir_digit_entry.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ir_digit_entry_if.sv
// Key-entry bus between the IR receiver side and ir_digit_entry.
// The master drives key events and observes the display field; the slave is the entry block.
interface ir_digit_entry_if #(
  parameter int NDIG = 6
);
  localparam int CW = $clog2(NDIG + 1);

  logic              iREADY;
  logic [7:0]        iKEY;
  logic [4*NDIG-1:0] oDIG;
  logic [NDIG-1:0]   oBLANK;
  logic [CW-1:0]     oCOUNT;
  logic              oLOCKED;
  logic              oENTER;
  logic              oERR;

  modport master (
    output iREADY, iKEY,
    input  oDIG, oBLANK, oCOUNT, oLOCKED, oENTER, oERR
  );

  modport slave (
    input  iREADY, iKEY,
    output oDIG, oBLANK, oCOUNT, oLOCKED, oENTER, oERR
  );
endinterface

// File: rtl/ir_digit_entry.sv
// Right-aligned decimal entry field driven by IR keycodes, with backspace/clear/enter,
// leading-zero blanking, locked-state blink and a timed error flash.
module ir_digit_entry #(
  parameter int NDIG       = 6,
  parameter int BLINK_HALF = 25000000,
  parameter int ERR_HOLD   = 12500000
) (
  input  logic            iCLK,
  input  logic            iRST_n,
  ir_digit_entry_if.slave bus
);
  localparam int CW = $clog2(NDIG + 1);
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int TW = $clog2(ERR_HOLD + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [TW-1:0] ERR_LOAD   = TW'(ERR_HOLD);
  localparam logic [CW-1:0] FULL       = CW'(NDIG);
  localparam logic [NDIG-1:0] BLANK_EMPTY = {{(NDIG-1){1'b1}}, 1'b0};

  typedef enum logic {ENTRY, LOCKED} state_t;
  typedef enum logic [2:0] {K_NONE, K_DIGIT, K_BACK, K_CLEAR, K_ENTER} key_t;

  state_t          state, state_n;
  logic [3:0]      dig   [NDIG];
  logic [3:0]      dig_n [NDIG];
  logic [CW-1:0]   count, count_n;
  logic [BW-1:0]   blink, blink_n;
  logic            phase, phase_n;  // 1 = visible half of the blink
  logic [TW-1:0]   tmr, tmr_n;
  logic            ready_d;
  logic            enter_r, enter_n;
  logic            err_r, err_n;
  logic [NDIG-1:0] blank_r, blank_n;
  logic            ev;
  key_t            kind;

  assign ev = bus.iREADY & ~ready_d;

  always_comb begin
    kind = K_NONE;
    if (ev) begin
      if (bus.iKEY <= 8'h09) kind = K_DIGIT;
      else begin
        case (bus.iKEY)
          8'h14:   kind = K_BACK;
          8'h0F:   kind = K_CLEAR;
          8'h17:   kind = K_ENTER;
          default: kind = K_NONE;
        endcase
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      state   <= ENTRY;
      for (int i = 0; i < NDIG; i++) dig[i] <= '0;
      count   <= '0;
      blink   <= '0;
      phase   <= 1'b1;
      tmr     <= '0;
      ready_d <= 1'b1;
      enter_r <= 1'b0;
      err_r   <= 1'b0;
      blank_r <= BLANK_EMPTY;
    end else begin
      state   <= state_n;
      dig     <= dig_n;
      count   <= count_n;
      blink   <= blink_n;
      phase   <= phase_n;
      tmr     <= tmr_n;
      ready_d <= bus.iREADY;
      enter_r <= enter_n;
      err_r   <= err_n;
      blank_r <= blank_n;
    end
  end

  always_comb begin
    state_n = state;
    dig_n   = dig;
    count_n = count;
    blink_n = blink;
    phase_n = phase;
    tmr_n   = tmr;
    enter_n = 1'b0;
    err_n   = 1'b0;
    blank_n = '0;

    case (state)
      ENTRY: begin
        // Any entry into LOCKED starts the blink in the visible phase.
        blink_n = '0;
        phase_n = 1'b1;
        case (kind)
          K_DIGIT: begin
            if (count < FULL) begin
              for (int i = NDIG - 1; i > 0; i--) dig_n[i] = dig[i-1];
              dig_n[0] = bus.iKEY[3:0];
              count_n  = count + 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end
          K_BACK: begin
            if (count != '0) begin
              for (int i = 0; i < NDIG - 1; i++) dig_n[i] = dig[i+1];
              dig_n[NDIG-1] = '0;
              count_n       = count - 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end
          K_CLEAR: begin
            for (int i = 0; i < NDIG; i++) dig_n[i] = '0;
            count_n = '0;
          end
          K_ENTER: begin
            if (count != '0) begin
              state_n = LOCKED;
              enter_n = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end
          default: ;
        endcase
      end
      LOCKED: begin
        if (blink == BLINK_LAST) begin
          blink_n = '0;
          phase_n = ~phase;
        end else begin
          blink_n = blink + 1'b1;
        end
        case (kind)
          K_DIGIT: begin
            for (int i = 0; i < NDIG; i++) dig_n[i] = '0;
            dig_n[0] = bus.iKEY[3:0];
            count_n  = CW'(1);
            state_n  = ENTRY;
          end
          K_BACK: begin
            state_n = ENTRY;
            if (count != '0) begin
              for (int i = 0; i < NDIG - 1; i++) dig_n[i] = dig[i+1];
              dig_n[NDIG-1] = '0;
              count_n       = count - 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end
          K_CLEAR: begin
            for (int i = 0; i < NDIG; i++) dig_n[i] = '0;
            count_n = '0;
            state_n = ENTRY;
          end
          K_ENTER: enter_n = 1'b1;
          default: ;
        endcase
      end
      default: state_n = ENTRY;
    endcase

    if (err_n)                tmr_n = ERR_LOAD;
    else if (kind == K_CLEAR) tmr_n = '0;
    else if (tmr != '0)       tmr_n = tmr - 1'b1;

    // Blanking is computed from next-state values so oBLANK is registered yet in step.
    for (int i = 0; i < NDIG; i++)
      blank_n[i] = (i != 0) && (CW'(i) >= count_n);
    if (state_n == LOCKED && !phase_n) blank_n = '1;
    if (tmr_n != '0)                   blank_n = '1;
  end

  logic [4*NDIG-1:0] dig_flat;
  always_comb begin
    dig_flat = '0;
    for (int i = 0; i < NDIG; i++) dig_flat[4*i +: 4] = dig[i];
  end

  assign bus.oDIG    = dig_flat;
  assign bus.oBLANK  = blank_r;
  assign bus.oCOUNT  = count;
  assign bus.oLOCKED = (state == LOCKED);
  assign bus.oENTER  = enter_r;
  assign bus.oERR    = err_r;
endmodule

// File: tb/tb_ir_digit_entry.sv
// Bench for ir_digit_entry: queue-based behavioural model compared every cycle,
// plus directed key sequences with literal expectations.
module tb_ir_digit_entry;
  localparam int NDIG = 4;
  localparam int BH   = 8;
  localparam int EH   = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ir_digit_entry_if #(.NDIG(NDIG)) bus();

  ir_digit_entry #(.NDIG(NDIG), .BLINK_HALF(BH), .ERR_HOLD(EH)) dut (
    .iCLK  (clk),
    .iRST_n(rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: entered digits oldest-first, lock age in cycles, error hold cycles left.
  int  q[$];
  bit  m_locked, m_enter, m_err, m_rd, m_valid;
  int  m_age, m_errleft;

  always @(posedge clk) begin
    bit ev, was_locked, clr;
    int k;
    if (!rst_n) begin
      q.delete();
      m_locked = 0; m_age = 0; m_errleft = 0;
      m_enter = 0; m_err = 0; m_rd = 1; m_valid = 1;
    end else begin
      ev = bus.iREADY && !m_rd;
      m_rd = bus.iREADY;
      k = int'(bus.iKEY);
      m_enter = 0; m_err = 0; clr = 0;
      was_locked = m_locked;
      if (ev) begin
        if (k <= 9) begin
          if (m_locked) begin
            q.delete(); q.push_back(k); m_locked = 0;
          end else if (q.size() < NDIG) q.push_back(k);
          else m_err = 1;
        end else if (k == 'h14) begin
          m_locked = 0;
          if (q.size() > 0) void'(q.pop_back());
          else m_err = 1;
        end else if (k == 'h0F) begin
          q.delete(); m_locked = 0; clr = 1;
        end else if (k == 'h17) begin
          if (m_locked) m_enter = 1;
          else if (q.size() > 0) begin m_locked = 1; m_enter = 1; end
          else m_err = 1;
        end
      end
      if (was_locked && m_locked) m_age++;
      else m_age = 0;
      if (m_err)              m_errleft = EH;
      else if (clr)           m_errleft = 0;
      else if (m_errleft > 0) m_errleft--;
    end
  end

  always @(negedge clk) begin
    logic [15:0] ed;
    logic [3:0]  eb;
    if (m_valid) begin
      ed = '0;
      for (int i = 0; i < q.size(); i++) ed[4*i +: 4] = 4'(q[q.size()-1-i]);
      eb = '0;
      for (int i = 1; i < NDIG; i++) eb[i] = (i >= q.size());
      if (m_locked && ((m_age / BH) % 2 == 1)) eb = '1;
      if (m_errleft > 0) eb = '1;
      chk("model_dig",    bus.oDIG,    ed);
      chk("model_blank",  bus.oBLANK,  eb);
      chk("model_count",  bus.oCOUNT,  q.size());
      chk("model_locked", bus.oLOCKED, m_locked);
      chk("model_enter",  bus.oENTER,  m_enter);
      chk("model_err",    bus.oERR,    m_err);
    end
  end

  logic       last_err, last_enter;
  logic [3:0] last_blank;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One key event: iREADY 0->1->0; outputs captured just after the event edge.
  task automatic press(input logic [7:0] k);
    bus.iKEY   = k;
    bus.iREADY = 1'b1;
    @(posedge clk);
    #1;
    last_err   = bus.oERR;
    last_enter = bus.oENTER;
    last_blank = bus.oBLANK;
    bus.iREADY = 1'b0;
    tick(1);
  endtask

  initial begin
    bus.iREADY = 1'b0;
    bus.iKEY   = 8'h00;
    rst_n      = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("rst_dig",    bus.oDIG,    16'h0000);
    chk("rst_count",  bus.oCOUNT,  0);
    chk("rst_blank",  bus.oBLANK,  4'b1110);
    chk("rst_locked", bus.oLOCKED, 0);

    press(8'h01); press(8'h02); press(8'h03);
    chk("k123_dig",   bus.oDIG,   16'h0123);
    chk("k123_count", bus.oCOUNT, 3);
    chk("k123_blank", bus.oBLANK, 4'b1000);

    press(8'h04);
    press(8'h05);
    chk("full_err",   last_err,   1);
    chk("full_dig",   bus.oDIG,   16'h1234);
    chk("full_count", bus.oCOUNT, 4);
    tick(3);
    chk("hold_blank_last", bus.oBLANK, 4'b1111);
    tick(1);
    chk("hold_blank_end",  bus.oBLANK, 4'b0000);

    press(8'h14); press(8'h14);
    chk("back2_dig",   bus.oDIG,   16'h0012);
    chk("back2_count", bus.oCOUNT, 2);
    press(8'h17);
    chk("enter_pulse",  last_enter,  1);
    chk("enter_locked", bus.oLOCKED, 1);
    tick(6);
    chk("blink_vis_end",   bus.oBLANK, 4'b1100);
    tick(1);
    chk("blink_invis",     bus.oBLANK, 4'b1111);
    tick(8);
    chk("blink_vis_again", bus.oBLANK, 4'b1100);

    press(8'h07);
    chk("lk7_dig",    bus.oDIG,    16'h0007);
    chk("lk7_count",  bus.oCOUNT,  1);
    chk("lk7_locked", bus.oLOCKED, 0);
    chk("lk7_blank",  bus.oBLANK,  4'b1110);

    bus.iKEY   = 8'h03;
    bus.iREADY = 1'b1;
    rst_n      = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("rdyhi_count", bus.oCOUNT, 0);
    chk("rdyhi_dig",   bus.oDIG,   16'h0000);
    bus.iREADY = 1'b0;
    tick(2);

    press(8'h14);
    chk("empty_back_err", last_err, 1);
    press(8'h17);
    chk("empty_enter_err",   last_err,   1);
    chk("empty_enter_noent", last_enter, 0);
    press(8'h0F);
    chk("clear_hold_blank", last_blank, 4'b1110);
    press(8'h0C);
    chk("mute_noerr", last_err,   0);
    chk("mute_count", bus.oCOUNT, 0);

    press(8'h04); press(8'h00);
    press(8'h17);
    press(8'h17);
    chk("reenter_pulse",  last_enter,  1);
    chk("reenter_locked", bus.oLOCKED, 1);
    press(8'h14);
    chk("lkback_dig",    bus.oDIG,    16'h0004);
    chk("lkback_locked", bus.oLOCKED, 0);
    press(8'h17);
    tick(10);
    press(8'h0F);
    chk("lkclr_count",  bus.oCOUNT,  0);
    chk("lkclr_locked", bus.oLOCKED, 0);

    press(8'h01); press(8'h02); press(8'h03);
    rst_n = 1'b0;
    tick(1);
    chk("midrst_dig",    bus.oDIG,    16'h0000);
    chk("midrst_count",  bus.oCOUNT,  0);
    chk("midrst_blank",  bus.oBLANK,  4'b1110);
    chk("midrst_locked", bus.oLOCKED, 0);
    rst_n = 1'b1;
    tick(1);
    press(8'h09);
    chk("post_rst_dig", bus.oDIG, 16'h0009);

    tick(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
